serial_mag_comparator: RTL

- Bit-serial N-bit magnitude comparator, MSB first.
- Sits directly upstream of the team's 1-bit comparator: it loads two operands, shifts them out one bit pair per cycle into an internal comparator_1bit instance, and consumes that instance's gt/lt/eq.
- Latches the first non-equal decision and returns a registered gt/lt/eq result through a valid/ready handshake.
- Used where area matters more than latency.

---
 rtl/serial_mag_comparator.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/serial_mag_comparator.sv
// serial_mag_comparator
//
// Bit-serial unsigned magnitude comparator, MSB first. Two WIDTH-bit
// operands are captured on an in_valid/in_ready handshake, then shifted out
// one bit pair per cycle into a comparator_1bit instance. The first bit pair
// that differs decides the result; equal operands produce eq. The result is
// held on gt/lt/eq and offered with out_valid until out_ready takes it.
//
// Optional build macro: SERIAL_CMP_EARLY_TERM_EN
//   When defined, the block finishes on the cycle of the first differing bit
//   pair instead of always shifting all WIDTH bits. Equal operands still take
//   WIDTH cycles.
//
// Parameters:
//   WIDTH      operand width in bits (>= 2)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operands a/b valid
//   in_ready   block can accept operands (only in IDLE)
//   a, b       operands
//   out_valid  result valid (DONE state)
//   out_ready  consumer accepts result
//   gt, lt, eq registered comparison result (unsigned)
//   busy       high while an operation is in SHIFT or DONE

module comparator_1bit (
  input  logic a,
  input  logic b,
  output logic gt,
  output logic lt,
  output logic eq
);
  assign gt = a & ~b;
  assign lt = ~a & b;
  assign eq = ~(a ^ b);
endmodule

module serial_mag_comparator #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             gt,
  output logic             lt,
  output logic             eq,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [CW-1:0]    cnt;
  logic             decided;

  logic bit_gt;
  logic bit_lt;
  logic bit_eq;

  // The current MSBs of the shift registers are the bit pair under test.
  comparator_1bit u_cmp (
    .a  (sa[WIDTH-1]),
    .b  (sb[WIDTH-1]),
    .gt (bit_gt),
    .lt (bit_lt),
    .eq (bit_eq)
  );

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sa        <= '0;
      sb        <= '0;
      cnt       <= '0;
      decided   <= 1'b0;
      out_valid <= 1'b0;
      gt        <= 1'b0;
      lt        <= 1'b0;
      eq        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sa      <= a;
            sb      <= b;
            cnt     <= CW'(WIDTH - 1);
            decided <= 1'b0;
            gt      <= 1'b0;
            lt      <= 1'b0;
            eq      <= 1'b0;
            state   <= SHIFT;
          end
        end

        SHIFT: begin
          sa  <= sa << 1;
          sb  <= sb << 1;
          cnt <= cnt - CW'(1);

          // Only the first differing bit pair counts; later pairs are
          // less significant and must not override it.
          if (!decided && bit_gt) begin
            gt      <= 1'b1;
            decided <= 1'b1;
          end
          if (!decided && bit_lt) begin
            lt      <= 1'b1;
            decided <= 1'b1;
          end

`ifdef SERIAL_CMP_EARLY_TERM_EN
          if (!decided && !bit_eq) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end else if (cnt == '0) begin
            state     <= DONE;
            out_valid <= 1'b1;
            if (!decided && bit_eq) eq <= 1'b1;
          end
`else
          if (cnt == '0) begin
            state     <= DONE;
            out_valid <= 1'b1;
            // The last pair is still undecided here: eq only if it matches.
            if (!decided && bit_eq) eq <= 1'b1;
          end
`endif
        end

        DONE: begin
          // gt/lt/eq stay as they are in IDLE until the next acceptance.
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end

        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
